// File: rtl/snoop_bcast_merge.sv
// snoop_bcast_merge: broadcasts one AC snoop to a masked set of ports and merges their CR responses
module snoop_bcast_merge #(
   parameter int unsigned NumPorts      = 2,
   parameter int unsigned AddrWidth     = 64,
   parameter bit          FilterIllegal = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    slv_ac_valid_i,
   output logic                    slv_ac_ready_o,
   input  logic [AddrWidth-1:0]    slv_ac_addr_i,
   input  logic [3:0]              slv_ac_snoop_i,
   input  logic [2:0]              slv_ac_prot_i,
   input  logic [NumPorts-1:0]     slv_ac_mask_i,
   output logic                    slv_cr_valid_o,
   input  logic                    slv_cr_ready_i,
   output logic [4:0]              slv_cr_resp_o,
   output logic [NumPorts-1:0]     mst_ac_valid_o,
   input  logic [NumPorts-1:0]     mst_ac_ready_i,
   output logic [AddrWidth-1:0]    mst_ac_addr_o,
   output logic [3:0]              mst_ac_snoop_o,
   output logic [2:0]              mst_ac_prot_o,
   input  logic [NumPorts-1:0]     mst_cr_valid_i,
   output logic [NumPorts-1:0]     mst_cr_ready_o,
   input  logic [5*NumPorts-1:0]   mst_cr_resp_i,
   output logic                    busy_o
);
   typedef enum logic [1:0] {IDLE, SNOOP, RESP} state_t;
   state_t              state_q;
   logic [NumPorts-1:0] pend_ac_q, pend_cr_q, cr_hs, pend_cr_d;
   logic [4:0]          resp_q, cr_merge;
   logic                legal;
   assign slv_ac_ready_o = state_q == IDLE;
   assign busy_o         = state_q != IDLE;
   assign slv_cr_valid_o = state_q == RESP;
   assign slv_cr_resp_o  = resp_q;
   assign mst_ac_valid_o = pend_ac_q;
   assign mst_cr_ready_o = pend_cr_q & ~pend_ac_q;
   assign cr_hs          = mst_cr_ready_o & mst_cr_valid_i;
   assign pend_cr_d      = pend_cr_q & ~cr_hs;
   assign legal          = !FilterIllegal || (slv_ac_snoop_i inside {4'b0000, 4'b0001, 4'b0010, 4'b0011,
                           4'b0111, 4'b1000, 4'b1001, 4'b1101, 4'b1110, 4'b1111});
   // OR together every response accepted this cycle
   always_comb begin
      cr_merge = '0;
      for (int p = 0; p < NumPorts; p++)
         if (cr_hs[p]) cr_merge |= mst_cr_resp_i[5*p +: 5];
   end
   // single-outstanding broadcast/collect FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         pend_ac_q      <= '0;
         pend_cr_q      <= '0;
         resp_q         <= '0;
         mst_ac_addr_o  <= '0;
         mst_ac_snoop_o <= '0;
         mst_ac_prot_o  <= '0;
      end else begin
         case (state_q)
            IDLE: if (slv_ac_valid_i) begin
               mst_ac_addr_o  <= slv_ac_addr_i;
               mst_ac_snoop_o <= slv_ac_snoop_i;
               mst_ac_prot_o  <= slv_ac_prot_i;
               resp_q         <= legal ? 5'b00000 : 5'b00010;
               if (!legal || slv_ac_mask_i == '0) state_q <= RESP;
               else begin
                  pend_ac_q <= slv_ac_mask_i;
                  pend_cr_q <= slv_ac_mask_i;
                  state_q   <= SNOOP;
               end
            end
            SNOOP: begin
               pend_ac_q <= pend_ac_q & ~mst_ac_ready_i;
               pend_cr_q <= pend_cr_d;
               resp_q    <= resp_q | cr_merge;
               if (pend_cr_d == '0) state_q <= RESP;
            end
            RESP: if (slv_cr_ready_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_snoop_bcast_merge.sv
// tb_snoop_bcast_merge: randomized snoop traffic against a transaction-level reference model
module tb_snoop_bcast_merge;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        slv_ac_valid_i = 1'b0;
   logic        slv_ac_ready_o;
   logic [63:0] slv_ac_addr_i = '0;
   logic [3:0]  slv_ac_snoop_i = '0;
   logic [2:0]  slv_ac_prot_i = '0;
   logic [3:0]  slv_ac_mask_i = '0;
   logic        slv_cr_valid_o;
   logic        slv_cr_ready_i = 1'b0;
   logic [4:0]  slv_cr_resp_o;
   logic [3:0]  mst_ac_valid_o;
   logic [3:0]  mst_ac_ready_i = '0;
   logic [63:0] mst_ac_addr_o;
   logic [3:0]  mst_ac_snoop_o;
   logic [2:0]  mst_ac_prot_o;
   logic [3:0]  mst_cr_valid_i = '0;
   logic [3:0]  mst_cr_ready_o;
   logic [19:0] mst_cr_resp_i = '0;
   logic        busy_o;

   logic        f_ac_valid = 1'b0, f_ac_ready, f_cr_valid, f_cr_ready = 1'b0, f_busy;
   logic [63:0] f_ac_addr, f_mst_addr;
   logic [3:0]  f_ac_snoop = '0, f_mst_snoop;
   logic [2:0]  f_mst_prot;
   logic [1:0]  f_ac_mask = '0, f_mst_valid, f_mst_ready = '0, f_cr_mvalid = '0, f_cr_mready;
   logic [4:0]  f_cr_resp;
   logic [9:0]  f_cr_mresp = '0;

   logic [15:0] legal_tab = 16'hE38F;
   int          errors = 0, checks = 0;

   always #5 clk_i = ~clk_i;

   snoop_bcast_merge #(.NumPorts(4), .AddrWidth(64), .FilterIllegal(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .slv_ac_valid_i(slv_ac_valid_i), .slv_ac_ready_o(slv_ac_ready_o),
      .slv_ac_addr_i(slv_ac_addr_i), .slv_ac_snoop_i(slv_ac_snoop_i),
      .slv_ac_prot_i(slv_ac_prot_i), .slv_ac_mask_i(slv_ac_mask_i),
      .slv_cr_valid_o(slv_cr_valid_o), .slv_cr_ready_i(slv_cr_ready_i),
      .slv_cr_resp_o(slv_cr_resp_o),
      .mst_ac_valid_o(mst_ac_valid_o), .mst_ac_ready_i(mst_ac_ready_i),
      .mst_ac_addr_o(mst_ac_addr_o), .mst_ac_snoop_o(mst_ac_snoop_o),
      .mst_ac_prot_o(mst_ac_prot_o),
      .mst_cr_valid_i(mst_cr_valid_i), .mst_cr_ready_o(mst_cr_ready_o),
      .mst_cr_resp_i(mst_cr_resp_i), .busy_o(busy_o)
   );

   snoop_bcast_merge #(.NumPorts(2), .AddrWidth(64), .FilterIllegal(1'b0)) dut_nf (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .slv_ac_valid_i(f_ac_valid), .slv_ac_ready_o(f_ac_ready),
      .slv_ac_addr_i(64'h2000), .slv_ac_snoop_i(f_ac_snoop),
      .slv_ac_prot_i(3'b010), .slv_ac_mask_i(f_ac_mask),
      .slv_cr_valid_o(f_cr_valid), .slv_cr_ready_i(f_cr_ready),
      .slv_cr_resp_o(f_cr_resp),
      .mst_ac_valid_o(f_mst_valid), .mst_ac_ready_i(f_mst_ready),
      .mst_ac_addr_o(f_mst_addr), .mst_ac_snoop_o(f_mst_snoop),
      .mst_ac_prot_o(f_mst_prot),
      .mst_cr_valid_i(f_cr_mvalid), .mst_cr_ready_o(f_cr_mready),
      .mst_cr_resp_i(f_cr_mresp), .busy_o(f_busy)
   );

   assign f_ac_addr = 64'h2000;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One upstream snoop. Port p becomes AC-ready acd[p] cycles after valid appears,
   // raises CR valid crd[p] cycles after its AC handshake (or from the start if early[p]),
   // and answers resp[5p+:5]. rst_at>0 asserts reset at that cycle instead of finishing.
   task automatic run_snoop(input logic [3:0] op, input logic [63:0] addr, input logic [2:0] prot,
                            input logic [3:0] mask, input logic [15:0] acd, input logic [15:0] crd,
                            input logic [3:0] early, input logic [19:0] resp, input int hold,
                            input int rst_at);
      logic       legal, dup, early_rdy, bad_fld, bad_ctl, bad_hold;
      logic [4:0] exp_resp, got_resp;
      logic [3:0] exp_vec, ac_vec, cr_vec, ac_done, crv, crh;
      int         exp_lat, c, t;
      legal = legal_tab[op];
      exp_vec = legal ? mask : 4'b0000;
      exp_resp = legal ? 5'b00000 : 5'b00010;
      exp_lat = 1;
      for (int p = 0; p < 4; p++)
         if (exp_vec[p]) begin
            exp_resp |= resp[5*p +: 5];
            t = 3 + int'(acd[4*p +: 4]) + (early[p] ? 0 : int'(crd[4*p +: 4]));
            if (t > exp_lat) exp_lat = t;
         end
      {dup, early_rdy, bad_fld, bad_ctl, bad_hold} = '0;
      {ac_vec, cr_vec, ac_done} = '0;
      @(negedge clk_i);
      slv_ac_valid_i = 1'b1;
      slv_ac_addr_i = addr;
      slv_ac_snoop_i = op;
      slv_ac_prot_i = prot;
      slv_ac_mask_i = mask;
      c = 0;
      while (!slv_ac_ready_o && c < 10) begin
         @(negedge clk_i);
         c++;
      end
      @(negedge clk_i);
      slv_ac_valid_i = 1'b0;
      slv_ac_addr_i = ~addr;
      slv_ac_snoop_i = ~op;
      slv_ac_prot_i = ~prot;
      slv_ac_mask_i = ~mask;
      c = 1;
      while (!slv_cr_valid_o && c < 64) begin
         if (c == rst_at) begin
            rst_ni = 1'b0;
            #1;
            check("reset_outputs", {mst_ac_valid_o, mst_cr_ready_o, slv_cr_valid_o, slv_ac_ready_o, busy_o, slv_cr_resp_o},
                  {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 5'b00000});
            mst_ac_ready_i = '0;
            mst_cr_valid_i = '0;
            @(negedge clk_i);
            rst_ni = 1'b1;
            return;
         end
         bad_ctl |= slv_ac_ready_o | !busy_o;
         for (int p = 0; p < 4; p++) begin
            if (mst_ac_valid_o[p] && (mst_ac_addr_o !== addr || mst_ac_snoop_o !== op || mst_ac_prot_o !== prot))
               bad_fld = 1'b1;
            early_rdy |= mst_cr_ready_o[p] & !ac_done[p];
            mst_ac_ready_i[p] = c >= 1 + int'(acd[4*p +: 4]);
            crv[p] = !cr_vec[p] && (early[p] || (mask[p] && ac_done[p] &&
                     c >= 2 + int'(acd[4*p +: 4]) + int'(crd[4*p +: 4])));
         end
         mst_cr_valid_i = crv;
         mst_cr_resp_i = resp;
         crh = mst_cr_ready_o & crv;
         dup |= |(ac_vec & mst_ac_valid_o & mst_ac_ready_i) | |(cr_vec & crh);
         ac_vec |= mst_ac_valid_o & mst_ac_ready_i;
         cr_vec |= crh;
         ac_done = ac_vec;
         @(negedge clk_i);
         c++;
      end
      mst_ac_ready_i = '0;
      mst_cr_valid_i = '0;
      check("latency", c, exp_lat);
      check("merged_resp", slv_cr_resp_o, exp_resp);
      check("ac_ports", ac_vec, exp_vec);
      check("cr_ports", cr_vec, exp_vec);
      check("dup_or_early", {dup, early_rdy}, 2'b00);
      check("ac_fields", bad_fld, 1'b0);
      check("busy_no_ready", bad_ctl, 1'b0);
      if (!slv_cr_valid_o) begin
         rst_ni = 1'b0;
         @(negedge clk_i);
         rst_ni = 1'b1;
         return;
      end
      got_resp = slv_cr_resp_o;
      for (int h = 0; h < hold; h++) begin
         bad_hold |= slv_cr_resp_o !== got_resp || !slv_cr_valid_o || slv_ac_ready_o || mst_ac_valid_o != 4'b0000;
         @(negedge clk_i);
      end
      bad_hold |= slv_cr_resp_o !== got_resp || !slv_cr_valid_o || slv_ac_ready_o;
      check("resp_hold", bad_hold, 1'b0);
      slv_cr_ready_i = 1'b1;
      @(negedge clk_i);
      slv_cr_ready_i = 1'b0;
      check("back_to_idle", {slv_ac_ready_o, busy_o, slv_cr_valid_o}, 3'b100);
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      check("reset_state", {slv_ac_ready_o, busy_o, slv_cr_valid_o, mst_ac_valid_o, mst_cr_ready_o, slv_cr_resp_o},
            {1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 5'b00000});
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("after_reset", {slv_ac_ready_o, busy_o, mst_ac_addr_o}, {1'b1, 1'b0, 64'h0});
      // READ_SHARED to all four ports, zero delays
      run_snoop(4'b0001, 64'h1000, 3'b000, 4'b1111, 16'h0000, 16'h0000, 4'b0000,
                {5'b00000, 5'b01000, 5'b00000, 5'b01000}, 0, 0);
      // CLEAN_INVALID to ports 0 and 2, port 0 slow on AC and pushing CR early
      run_snoop(4'b1001, 64'h2040, 3'b001, 4'b0101, 16'h0003, 16'h0000, 4'b0001,
                {5'b00000, 5'b00101, 5'b00000, 5'b00000}, 1, 0);
      // illegal opcode answered locally
      run_snoop(4'b0100, 64'h3000, 3'b000, 4'b1111, 16'h0000, 16'h0000, 4'b0000, 20'hFFFFF, 0, 0);
      // empty mask, response held off for 5 cycles
      run_snoop(4'b0111, 64'h4000, 3'b010, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 20'hFFFFF, 5, 0);
      // reset mid-SNOOP with ports 2 and 3 still pending, then a clean snoop
      run_snoop(4'b0001, 64'h5000, 3'b000, 4'b1111, 16'hFF00, 16'h0000, 4'b0000, 20'hFFFFF, 0, 4);
      run_snoop(4'b0000, 64'h6000, 3'b000, 4'b0001, 16'h0000, 16'h0000, 4'b0000, 20'hFFFE0, 0, 0);
      for (int n = 0; n < 40; n++)
         run_snoop(4'($urandom_range(0, 15)), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)), 16'($urandom) & 16'h3333, 16'($urandom) & 16'h3333,
                   4'($urandom_range(0, 15)), 20'($urandom), $urandom_range(0, 3), 0);
      // opcode 0100 is broadcast when filtering is disabled
      @(negedge clk_i);
      f_ac_valid = 1'b1;
      f_ac_snoop = 4'b0100;
      f_ac_mask = 2'b10;
      check("nf_ac_ready", f_ac_ready, 1'b1);
      @(negedge clk_i);
      f_ac_valid = 1'b0;
      check("nf_ac_valid", {f_mst_valid, f_mst_snoop, f_mst_addr}, {2'b10, 4'b0100, f_ac_addr});
      f_mst_ready = 2'b10;
      @(negedge clk_i);
      f_mst_ready = 2'b00;
      check("nf_cr_ready", f_cr_mready, 2'b10);
      f_cr_mvalid = 2'b10;
      f_cr_mresp = {5'b10001, 5'b00000};
      @(negedge clk_i);
      f_cr_mvalid = 2'b00;
      check("nf_resp", {f_cr_valid, f_cr_resp}, {1'b1, 5'b10001});
      f_cr_ready = 1'b1;
      @(negedge clk_i);
      f_cr_ready = 1'b0;
      check("nf_idle", {f_busy, f_ac_ready}, 2'b01);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
